// File: rtl/sump_pattern_gen.sv
// -----------------------------------------------------------------------------
// sump_pattern_gen
//
// Register-programmed test-pattern engine feeding the logic-analyzer sampler
// input mux. The command decoder writes mode/period/count/seed; a start pulse
// launches a burst of pattern words, paced by a step-period prescaler and by
// the sampler's ready handshake.
//
// Optional feature macro: TPG_LFSR_EN
//   defined   -> mode 3 is a Galois LFSR using the low DW bits of LFSR_POLY
//   undefined -> no LFSR logic; mode 3 behaves like constant (mode 4)
//
// Ports:
//   clock       system clock
//   reset_n     asynchronous active-low reset
//   cfg_we      config write strobe (ignored while busy)
//   cfg_addr    0=mode, 1=period, 2=count, 3=seed/mask
//   cfg_data    config write data, truncated/extended to each field width
//   start       pulse: begin burst (IDLE only)
//   abort       pulse: end burst at once, no done pulse (RUN only)
//   ready       sampler accepts data this cycle; 0 freezes prescaler/pattern
//   data_out    current pattern word
//   data_valid  data_out is valid (FSM in RUN)
//   busy        FSM in RUN
//   done        one-cycle pulse after the final step of a counted burst
// -----------------------------------------------------------------------------
module sump_pattern_gen #(
    parameter int          DW        = 32,
    parameter int          CNT_W     = 16,
    parameter int          PER_W     = 16,
    parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [31:0]   cfg_data,
    input  logic          start,
    input  logic          abort,
    input  logic          ready,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] MODE_CNT  = 3'd0;
    localparam logic [2:0] MODE_WALK = 3'd1;
    localparam logic [2:0] MODE_TOG  = 3'd2;
`ifdef TPG_LFSR_EN
    localparam logic [2:0]    MODE_LFSR = 3'd3;
    localparam logic [DW-1:0] POLY_DW   = DW'(LFSR_POLY);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_mode;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_pre;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_step_cnt;
    logic [DW-1:0]    r_seed;
    logic [DW-1:0]    r_data;

    logic             w_load;
    logic             w_step;
    logic             w_run;
    logic [CNT_W-1:0] w_step_cnt_inc;
    logic [DW-1:0]    w_init;
    logic [DW-1:0]    w_adv;

    assign w_run          = (r_state == ST_RUN);
    assign w_step_cnt_inc = r_step_cnt + CNT_W'(1);

    // -------------------------------------------------------------------------
    // FSM next-state and step/load strobes
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // abort outranks both a step and a coincident start
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (ready && (r_pre == r_period)) begin
                    w_step = 1'b1;
                    // count==0 is free-run; otherwise the step reaching count ends it
                    if ((r_count != '0) && (w_step_cnt_inc == r_count)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Pattern initial value and per-step advance
    // -------------------------------------------------------------------------
    always_comb begin
        w_init = r_seed;
        case (r_mode)
            MODE_CNT,
            MODE_TOG:  w_init = '0;
            MODE_WALK: w_init = DW'(1);
`ifdef TPG_LFSR_EN
            // an all-zero LFSR would lock up, so a zero seed starts at 1
            MODE_LFSR: w_init = (r_seed == '0) ? DW'(1) : r_seed;
`endif
            default:   w_init = r_seed;
        endcase
    end

    always_comb begin
        w_adv = r_data;
        case (r_mode)
            MODE_CNT:  w_adv = r_data + DW'(1);
            MODE_WALK: w_adv = {r_data[DW-2:0], r_data[DW-1]};
            MODE_TOG:  w_adv = r_data ^ r_seed;
`ifdef TPG_LFSR_EN
            MODE_LFSR: w_adv = (r_data >> 1) ^ (r_data[0] ? POLY_DW : '0);
`endif
            default:   w_adv = r_data;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: pattern word, prescaler, step counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_pre      <= '0;
            r_step_cnt <= '0;
        end else if (w_load) begin
            r_data     <= w_init;
            r_pre      <= '0;
            r_step_cnt <= '0;
        end else if (w_step) begin
            r_data     <= w_adv;
            r_pre      <= '0;
            r_step_cnt <= w_step_cnt_inc;
        end else if (w_run && ready && !abort) begin
            r_pre <= r_pre + PER_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Config registers; frozen while a burst runs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= '0;
            r_period <= '0;
            r_count  <= '0;
            r_seed   <= '0;
        end else if (cfg_we && !w_run) begin
            case (cfg_addr)
                2'd0:    r_mode   <= cfg_data[2:0];
                2'd1:    r_period <= PER_W'(cfg_data);
                2'd2:    r_count  <= CNT_W'(cfg_data);
                default: r_seed   <= DW'(cfg_data);
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = w_run;
    assign busy       = w_run;
    assign done       = (r_state == ST_DONE);

endmodule
